// File: rtl/bcd2bin_seq_pkg.sv
// Shared types and constants for the sequential BCD-to-binary converter.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Smallest result width that can hold 10^digits - 1.
  function automatic int min_bin_w(input int digits);
    int p;
    p = 1;
    for (int i = 0; i < digits; i++) begin
      p = p * 10;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/bcd2bin_seq_if.sv
// Input and output valid/ready channels of the BCD-to-binary converter.
interface bcd2bin_seq_if #(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
);
  logic                  in_valid;
  logic                  in_ready;
  logic [4*DIGITS-1:0]   in_bcd;
  logic                  out_valid;
  logic                  out_ready;
  logic [BIN_W-1:0]      out_bin;
  logic                  out_err;

  modport master (
    output in_valid, in_bcd, out_ready,
    input  in_ready, out_valid, out_bin, out_err
  );

  modport slave (
    input  in_valid, in_bcd, out_ready,
    output in_ready, out_valid, out_bin, out_err
  );
endinterface

// File: rtl/bcd2bin_seq_digit_mac.sv
// One Horner step of the conversion: acc*10 + digit, with a digit range flag.
module bcd_digit_mac
  import bcd_pkg::*;
#(
  parameter int BIN_W = 7
) (
  input  logic [BIN_W-1:0] acc,
  input  logic [3:0]       digit,
  output logic [BIN_W-1:0] acc_next,
  output logic             digit_ok
);

  localparam int WIDE_W = BIN_W + 4;

  logic [WIDE_W-1:0] acc_wide;
  logic [WIDE_W-1:0] prod;
  logic              unused_prod_hi;

  // acc*10 as two shifts; computed wide, then truncated (legal digits never overflow)
  always_comb begin
    acc_wide = {4'b0000, acc};
    prod     = (acc_wide << 3) + (acc_wide << 1) + {{BIN_W{1'b0}}, digit};
  end

  assign acc_next       = prod[BIN_W-1:0];
  assign digit_ok       = (digit <= DIGIT_MAX);
  assign unused_prod_hi = ^prod[WIDE_W-1:BIN_W];

endmodule

// File: rtl/bcd2bin_seq.sv
// Sequential BCD-to-binary converter: one digit per clock, MSD first.
//
// state | meaning
// IDLE  | waiting for an input; in_ready high
// CONV  | folding one digit per cycle into acc
// DONE  | result held on out_*; waiting for out_ready
module bcd2bin_seq
  import bcd_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int BIN_W  = 7
) (
  input  logic          clk,
  input  logic          rst_n,
  bcd2bin_seq_if.slave  bus
);

  localparam int SR_W  = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  if (DIGITS < 1 || DIGITS > 5) begin : g_bad_digits
    $error("bcd2bin_seq: DIGITS must be in 1..5");
  end
  if (BIN_W < min_bin_w(DIGITS)) begin : g_bad_width
    $error("bcd2bin_seq: BIN_W too narrow for DIGITS");
  end

  state_t           state;
  state_t           state_next;
  logic [SR_W-1:0]  sr;
  logic [CNT_W-1:0] cnt;
  logic [BIN_W-1:0] acc;
  logic [BIN_W-1:0] acc_next;
  logic             err;
  logic             err_next;
  logic             digit_ok;
  logic [3:0]       digit;
  logic [BIN_W-1:0] bin_q;
  logic             err_q;
  logic             accept;
  logic             last_digit;
  logic             ready_idle;
  logic             valid_done;

  assign digit      = sr[SR_W-1 -: 4];
  assign last_digit = (cnt == CNT_W'(1));
  assign err_next   = err | ~digit_ok;

  bcd_digit_mac #(.BIN_W(BIN_W)) u_mac (
    .acc      (acc),
    .digit    (digit),
    .acc_next (acc_next),
    .digit_ok (digit_ok)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_next = state;
    ready_idle = 1'b0;
    valid_done = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        ready_idle = 1'b1;
        if (bus.in_valid) begin
          accept     = 1'b1;
          state_next = CONV;
        end
      end
      CONV: begin
        if (last_digit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        valid_done = 1'b1;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: capture on accept, one digit per CONV cycle, register result on the last digit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      cnt   <= '0;
      acc   <= '0;
      err   <= 1'b0;
      bin_q <= '0;
      err_q <= 1'b0;
    end else if (accept) begin
      sr  <= bus.in_bcd;
      cnt <= CNT_W'(DIGITS);
      acc <= '0;
      err <= 1'b0;
    end else if (state == CONV) begin
      sr  <= sr << 4;
      cnt <= cnt - CNT_W'(1);
      acc <= acc_next;
      err <= err_next;
      if (last_digit) begin
        bin_q <= err_next ? '0 : acc_next;
        err_q <= err_next;
      end
    end
  end

  assign bus.in_ready  = ready_idle;
  assign bus.out_valid = valid_done;
  assign bus.out_bin   = bin_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Self-checking bench for bcd2bin_seq (DIGITS=2, BIN_W=7).
module tb_bcd2bin_seq;
  localparam int DIGITS = 2;
  localparam int BIN_W  = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bcd2bin_seq_if #(.DIGITS(DIGITS), .BIN_W(BIN_W)) bus ();

  bcd2bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: decimal value of the BCD word; any nibble above 9 forces 0 and err.
  function automatic void ref_conv(input logic [7:0] bcd, output int val, output bit bad);
    int pw;
    val = 0;
    bad = 1'b0;
    pw  = 1;
    for (int k = 0; k < DIGITS; k++) begin
      int d;
      d = int'(bcd[4*k +: 4]);
      if (d > 9) bad = 1'b1;
      val = val + d * pw;
      pw  = pw * 10;
    end
    if (bad) val = 0;
  endfunction

  // Drive one conversion, optionally stall the consumer, complete the handshake.
  task automatic convert(input logic [7:0] bcd, input int stall,
                         output int bin, output bit err, output int acc_cyc, output int lat);
    int n;
    logic [31:0] r;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 50) begin tick(); n++; end
    bus.in_valid = 1'b1;
    bus.in_bcd   = bcd;
    tick();
    acc_cyc      = cyc;
    bus.in_valid = 1'b0;
    r            = $urandom;
    bus.in_bcd   = r[7:0];
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bus.out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout: out_valid=%b required 1 (bcd=%h)", bus.out_valid, bcd);
    end
    bin = int'(bus.out_bin);
    err = bus.out_err;
    lat = cyc - acc_cyc;
    if (stall > 0) begin
      bus.out_ready = 1'b0;
      for (int i = 0; i < stall; i++) begin
        tick();
        checks++;
        if (bus.out_valid !== 1'b1 || int'(bus.out_bin) != bin || bus.out_err !== err || bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_hold: valid=%b bin=%0d err=%b in_ready=%b required 1/%0d/%b/0",
                   bus.out_valid, bus.out_bin, bus.out_err, bus.in_ready, bin, err);
        end
      end
    end
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_handshake: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.in_bcd    = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.out_bin !== 7'd0 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b bin=%0d err=%b in_ready=%b required 0/0/0/1",
               bus.out_valid, bus.out_bin, bus.out_err, bus.in_ready);
    end
    bus.in_valid = 1'b1;
    bus.in_bcd   = 8'h47;
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: in_ready=%b required 0", bus.in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid);
    end
    #1 rst_n = 1'b1;
    repeat (3) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
        errors++;
        $display("FAIL reset_discard: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_single();
    int t0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = 8'h47;
    tick();
    t0 = cyc;
    bus.in_valid = 1'b0;
    bus.in_bcd   = 8'h00;
    checks++;
    if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_accept: in_ready=%b out_valid=%b required 0/0", bus.in_ready, bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_early: out_valid=%b required 0", bus.out_valid);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_bin !== 7'd47 || bus.out_err !== 1'b0 || (cyc - t0) != 2) begin
      errors++;
      $display("FAIL single_result: valid=%b bin=%0d err=%b lat=%0d required 1/47/0/2",
               bus.out_valid, bus.out_bin, bus.out_err, cyc - t0);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL single_release: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_sweep();
    int bin, acc_cyc, lat, prev;
    bit err;
    logic [7:0] bcd;
    prev = -1;
    bus.out_ready = 1'b1;
    for (int hi = 0; hi < 10; hi++) begin
      for (int lo = 0; lo < 10; lo++) begin
        bcd = {4'(hi), 4'(lo)};
        convert(bcd, 0, bin, err, acc_cyc, lat);
        checks++;
        if (bin != 10 * hi + lo || err !== 1'b0 || lat != DIGITS) begin
          errors++;
          $display("FAIL sweep_value: bcd=%h bin=%0d err=%b lat=%0d required %0d/0/%0d",
                   bcd, bin, err, lat, 10 * hi + lo, DIGITS);
        end
        if (prev >= 0) begin
          checks++;
          if (acc_cyc - prev != DIGITS + 2) begin
            errors++;
            $display("FAIL sweep_spacing: bcd=%h spacing=%0d required %0d", bcd, acc_cyc - prev, DIGITS + 2);
          end
        end
        prev = acc_cyc;
      end
    end
  endtask

  task automatic test_error();
    int bin, acc_cyc, lat;
    bit err;
    convert(8'h3A, 0, bin, err, acc_cyc, lat);
    checks++;
    if (bin != 0 || err !== 1'b1 || lat != DIGITS) begin
      errors++;
      $display("FAIL error_digit: bin=%0d err=%b lat=%0d required 0/1/%0d", bin, err, lat, DIGITS);
    end
    convert(8'h12, 0, bin, err, acc_cyc, lat);
    checks++;
    if (bin != 12 || err !== 1'b0) begin
      errors++;
      $display("FAIL error_cleared: bin=%0d err=%b required 12/0", bin, err);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] r;
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = 8'h99;
    tick();
    bus.in_valid = 1'b0;
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_bin !== 7'd99 || bus.out_err !== 1'b0) begin
      errors++;
      $display("FAIL bp_result: valid=%b bin=%0d err=%b required 1/99/0", bus.out_valid, bus.out_bin, bus.out_err);
    end
    for (int i = 0; i < 5; i++) begin
      r = $urandom;
      bus.in_valid = r[0];
      bus.in_bcd   = 8'h11;
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_bin !== 7'd99 || bus.out_err !== 1'b0 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold: valid=%b bin=%0d err=%b in_ready=%b required 1/99/0/0",
                 bus.out_valid, bus.out_bin, bus.out_err, bus.in_ready);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_idle: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_reset_mid_conv();
    int bin, acc_cyc, lat;
    bit err;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_bcd    = 8'h58;
    tick();
    bus.in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midconv_reset: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready);
    end
    repeat (2) tick();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL midconv_discard: out_valid=%b required 0", bus.out_valid);
      end
    end
    convert(8'h05, 0, bin, err, acc_cyc, lat);
    checks++;
    if (bin != 5 || err !== 1'b0 || lat != DIGITS) begin
      errors++;
      $display("FAIL midconv_next: bin=%0d err=%b lat=%0d required 5/0/%0d", bin, err, lat, DIGITS);
    end
  endtask

  task automatic test_random();
    int bin, acc_cyc, lat, exp_val, stall;
    bit err, exp_err;
    logic [31:0] r;
    logic [7:0] bcd;
    for (int i = 0; i < 60; i++) begin
      r     = $urandom;
      bcd   = r[7:0];
      stall = int'($urandom_range(0, 3));
      ref_conv(bcd, exp_val, exp_err);
      convert(bcd, stall, bin, err, acc_cyc, lat);
      checks++;
      if (bin != exp_val || err !== exp_err || lat != DIGITS) begin
        errors++;
        $display("FAIL random_conv: bcd=%h bin=%0d err=%b lat=%0d required %0d/%b/%0d",
                 bcd, bin, err, lat, exp_val, exp_err, DIGITS);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sweep();
    test_error();
    test_backpressure();
    test_reset_mid_conv();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
